vdp_clock_reset_sequencer: RTL and testbench



---
 rtl/vdp_clock_reset_sequencer.sv | 120 ++++++++++++
 tb/tb_vdp_clock_reset_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vdp_clock_reset_sequencer.sv
// rtl/vdp_clock_reset_sequencer.sv - PLL-lock driven VDP reset release and 21/10/5 MHz enable generation
module vdp_clock_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DIV_21M            = 10,
    parameter int CNT_W              = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       sys_reset_n,
    output logic       ena_21m,
    output logic       ena_10m,
    output logic       ena_5m,
    output logic       locked,
    output logic [7:0] lock_lost_count
);

    localparam int DIV_W = (DIV_21M > 2) ? $clog2(DIV_21M) : 1;
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_21M - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, lock_s_q, locked_q;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic             sys_reset_n_q, run_d;
    logic             ena21_q, ena21_d, ena10_q, ena10_d, ena5_q, ena5_d;
    logic [7:0]       lost_q, lost_d;

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        lost_d  = lost_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                stab_d = '0;
                if (lock_s_q) state_d = ST_STABILIZE;
            end
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = ST_RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            ST_RUN: begin
                stab_d = '0;
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                stab_d  = '0;
            end
        endcase

        // Divider and phase restart from zero on every RUN entry so enable phase is fixed relative to reset release
        run_d   = (state_d == ST_RUN);
        div_d   = '0;
        phase_d = 2'd0;
        if (run_d && (state_q == ST_RUN)) begin
            div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            phase_d = ena21_q ? phase_q + 2'd1 : phase_q;
        end
        ena21_d = run_d && (div_d == DIV_LAST);
        ena10_d = ena21_d && phase_d[0];
        ena5_d  = ena21_d && (phase_d == 2'd3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_WAIT_LOCK;
            sync1_q       <= 1'b0;
            lock_s_q      <= 1'b0;
            locked_q      <= 1'b0;
            stab_q        <= '0;
            div_q         <= '0;
            phase_q       <= 2'd0;
            sys_reset_n_q <= 1'b0;
            ena21_q       <= 1'b0;
            ena10_q       <= 1'b0;
            ena5_q        <= 1'b0;
            lost_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= pll_lock;
            lock_s_q      <= sync1_q;
            locked_q      <= lock_s_q;
            stab_q        <= stab_d;
            div_q         <= div_d;
            phase_q       <= phase_d;
            sys_reset_n_q <= run_d;
            ena21_q       <= ena21_d;
            ena10_q       <= ena10_d;
            ena5_q        <= ena5_d;
            lost_q        <= lost_d;
        end
    end

    assign sys_reset_n     = sys_reset_n_q;
    assign ena_21m         = ena21_q;
    assign ena_10m         = ena10_q;
    assign ena_5m          = ena5_q;
    assign locked          = locked_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_vdp_clock_reset_sequencer.sv
// tb/tb_vdp_clock_reset_sequencer.sv - directed self-checking bench for vdp_clock_reset_sequencer
module tb_vdp_clock_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_lock;
    logic       sys_reset_n;
    logic       ena_21m;
    logic       ena_10m;
    logic       ena_5m;
    logic       locked;
    logic [7:0] lock_lost_count;

    int checks = 0;
    int errors = 0;

    vdp_clock_reset_sequencer #(
        .LOCK_STABLE_CYCLES(16),
        .DIV_21M           (10),
        .CNT_W             (5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_lock       (pll_lock),
        .sys_reset_n    (sys_reset_n),
        .ena_21m        (ena_21m),
        .ena_10m        (ena_10m),
        .ena_5m         (ena_5m),
        .locked         (locked),
        .lock_lost_count(lock_lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_all();
        return {19'd0, sys_reset_n, ena_21m, ena_10m, ena_5m, locked, lock_lost_count};
    endfunction

    // Checks n RUN cycles starting at the first cycle with sys_reset_n=1 (c=0)
    task automatic run_window(input int n);
        for (int c = 0; c < n; c++) begin
            logic e21, e10, e5;
            e21 = ((c % 10) == 9);
            e10 = e21 && (((c / 10) % 2) == 1);
            e5  = e21 && (((c / 10) % 4) == 3);
            chk("run_sys_reset_n", {31'd0, sys_reset_n}, 32'd1);
            chk("run_ena_21m", {31'd0, ena_21m}, {31'd0, e21});
            chk("run_ena_10m", {31'd0, ena_10m}, {31'd0, e10});
            chk("run_ena_5m", {31'd0, ena_5m}, {31'd0, e5});
            tick();
        end
    endtask

    // pll_lock rises after edge T: locked at T+3, sys_reset_n at T+19, then enable pattern
    task automatic relock_and_check();
        pll_lock = 1'b1;
        tick();
        tick();
        chk("locked_before_T3", {31'd0, locked}, 32'd0);
        tick();
        chk("locked_at_T3", {31'd0, locked}, 32'd1);
        repeat (15) tick();
        chk("sys_reset_n_at_T18", {31'd0, sys_reset_n}, 32'd0);
        chk("no_ena_before_run", {29'd0, ena_21m, ena_10m, ena_5m}, 32'd0);
        tick();
        chk("sys_reset_n_at_T19", {31'd0, sys_reset_n}, 32'd1);
        run_window(80);
    endtask

    initial begin
        reset_n  = 1'b0;
        pll_lock = 1'b0;

        // Power-up ordering
        repeat (5) begin
            tick();
            chk("reset_outputs_zero", outs_all(), 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("no_lock_outputs_zero", outs_all(), 32'd0);
        end

        // Lock glitch during STABILIZE: drop for 3 clk at stab count 10
        pll_lock = 1'b1;
        repeat (13) tick();
        chk("glitch_pre_sys_reset_n", {31'd0, sys_reset_n}, 32'd0);
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("glitch_sys_reset_n", {31'd0, sys_reset_n}, 32'd0);
        chk("glitch_locked_low", {31'd0, locked}, 32'd0);
        relock_and_check();
        chk("glitch_lost_count", {24'd0, lock_lost_count}, 32'd0);

        // Clean lock phase check is covered above; now lock loss mid-RUN (div_cnt=3)
        repeat (3) tick();
        pll_lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("loss_no_ena", {29'd0, ena_21m, ena_10m, ena_5m}, 32'd0);
        end
        tick();
        chk("loss_sys_reset_n", {31'd0, sys_reset_n}, 32'd0);
        chk("loss_no_ena_3", {29'd0, ena_21m, ena_10m, ena_5m}, 32'd0);
        chk("loss_count_1", {24'd0, lock_lost_count}, 32'd1);
        relock_and_check();
        chk("relock_count_1", {24'd0, lock_lost_count}, 32'd1);

        // Saturation
        repeat (2) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("sat_count_2", {24'd0, lock_lost_count}, 32'd2);
        for (int n = 3; n <= 262; n++) begin
            pll_lock = 1'b1;
            repeat (19) tick();
            chk("sat_in_run", {31'd0, sys_reset_n}, 32'd1);
            repeat (2) tick();
            pll_lock = 1'b0;
            repeat (3) tick();
            chk("sat_count", {24'd0, lock_lost_count}, (n > 255) ? 32'd255 : n);
        end
        chk("sat_final", {24'd0, lock_lost_count}, 32'd255);

        // Async reset mid-RUN with lock held
        pll_lock = 1'b1;
        repeat (19) tick();
        chk("pre_areset_run", {31'd0, sys_reset_n}, 32'd1);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_outputs_zero", outs_all(), 32'd0);
        #1;
        reset_n = 1'b1;
        relock_and_check();
        chk("areset_count_zero", {24'd0, lock_lost_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
